sr04_ranger: RTL and testbench

- HC-SR04 ultrasonic ranging controller; sits downstream of the usec tick generator and consumes its 1-cycle `clk_usec` strobe.
- Generates the trigger pulse, synchronises and times the echo pulse, and converts its width to centimetres (58 us/cm) incrementally.
- Publishes each result with a 1-cycle valid strobe for display or bus-register stages.
- Supports single-shot and free-running (auto) measurement with a timeout and a fixed measurement period.

---
 rtl/sr04_pkg.sv | 24 ++
 rtl/sr04_echo_sync.sv | 38 +++
 rtl/sr04_ranger.sv | 170 +++++++++++++++++
 tb/tb_sr04_ranger.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr04_pkg.sv
// sr04_pkg: shared definitions for the HC-SR04 ranging controller.
//   state_t        - controller state encoding (3 bit)
//   DEF_*          - default timing constants in microsecond ticks
//   US_W           - width of the time-since-trigger counter
package sr04_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TRIG   = 3'd1,
        WAIT_H = 3'd2,
        MEAS   = 3'd3,
        HOLD   = 3'd4
    } state_t;

    localparam int DEF_TRIG_US    = 11;
    localparam int DEF_US_PER_CM  = 58;
    localparam int DEF_TIMEOUT_US = 30000;
    localparam int DEF_PERIOD_US  = 60000;
    localparam int DEF_CM_W       = 12;

    // Wide enough for a full measurement period of 60000 us.
    localparam int US_W = 17;

endpackage

// File: rtl/sr04_echo_sync.sv
// sr04_echo_sync: brings the asynchronous echo pin into the clk domain and
// produces registered single-cycle rise/fall pulses.
//   clk     - system clock
//   reset_p - asynchronous, active-high reset
//   echo_i  - raw sensor echo pin
//   rise_o  - 1-cycle pulse on a 0->1 transition of the synchronised echo
//   fall_o  - 1-cycle pulse on a 1->0 transition of the synchronised echo
// Pin-to-pulse latency is 3 clk (two synchroniser stages plus the pulse flop).
module sr04_echo_sync (
    input  logic clk,
    input  logic reset_p,
    input  logic echo_i,
    output logic rise_o,
    output logic fall_o
);
    logic [1:0] sync_q;
    logic       level_q;
    logic       rise_q;
    logic       fall_q;

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], echo_i};
            level_q <= sync_q[1];
            rise_q  <= sync_q[1] & ~level_q;
            fall_q  <= ~sync_q[1] & level_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/sr04_ranger.sv
// sr04_ranger: HC-SR04 ultrasonic ranging controller.
//   clk          - system clock
//   reset_p      - asynchronous, active-high reset
//   clk_usec     - 1-cycle strobe once per microsecond
//   start        - single-shot request, only looked at in IDLE
//   auto_en      - free-running measurement enable
//   echo         - asynchronous sensor echo pin
//   trig         - registered sensor trigger
//   distance_cm  - last valid distance in centimetres
//   valid        - 1-cycle strobe when distance_cm updates
//   timeout_err  - 1-cycle strobe when a measurement times out
//   busy         - high in every state except IDLE
module sr04_ranger
    import sr04_pkg::*;
#(
    parameter int TRIG_US    = DEF_TRIG_US,
    parameter int US_PER_CM  = DEF_US_PER_CM,
    parameter int TIMEOUT_US = DEF_TIMEOUT_US,
    parameter int PERIOD_US  = DEF_PERIOD_US,
    parameter int CM_W       = DEF_CM_W
) (
    input  logic            clk,
    input  logic            reset_p,
    input  logic            clk_usec,
    input  logic            start,
    input  logic            auto_en,
    input  logic            echo,
    output logic            trig,
    output logic [CM_W-1:0] distance_cm,
    output logic            valid,
    output logic            timeout_err,
    output logic            busy
);
    localparam int               SUB_W       = $clog2(US_PER_CM + 1);
    localparam logic [US_W-1:0]  TRIG_LAST   = US_W'(TRIG_US - 1);
    localparam logic [US_W-1:0]  TIMEOUT_LIM = US_W'(TIMEOUT_US);
    localparam logic [US_W-1:0]  PERIOD_LIM  = US_W'(PERIOD_US);
    localparam logic [SUB_W-1:0] SUB_LAST    = SUB_W'(US_PER_CM - 1);
    localparam logic [CM_W-1:0]  CM_MAX      = {CM_W{1'b1}};

    state_t           state_q;
    logic [US_W-1:0]  us_cnt_q;
    logic [US_W-1:0]  us_cnt_d;
    logic [US_W-1:0]  rise_us_q;
    logic [US_W-1:0]  echo_us;
    logic [SUB_W-1:0] sub_cnt_q;
    logic [SUB_W-1:0] sub_cnt_d;
    logic [CM_W-1:0]  cm_acc_q;
    logic [CM_W-1:0]  cm_acc_d;
    logic [CM_W-1:0]  distance_q;
    logic             trig_q;
    logic             valid_q;
    logic             timeout_q;
    logic             echo_rise;
    logic             echo_fall;

    sr04_echo_sync u_echo_sync (
        .clk     (clk),
        .reset_p (reset_p),
        .echo_i  (echo),
        .rise_o  (echo_rise),
        .fall_o  (echo_fall)
    );

    // Time since trigger start, advanced by the usec strobe.
    always_comb begin
        us_cnt_d = us_cnt_q;
        if (clk_usec) begin
            us_cnt_d = us_cnt_q + US_W'(1);
        end
    end

    // Echo width so far; rise_us_q holds the trigger-relative time of the rise.
    assign echo_us = us_cnt_q - rise_us_q;

    // Incremental us -> cm conversion: every US_PER_CM ticks add one cm,
    // holding at the top of the range instead of wrapping.
    always_comb begin
        sub_cnt_d = sub_cnt_q;
        cm_acc_d  = cm_acc_q;
        if (clk_usec) begin
            if (sub_cnt_q == SUB_LAST) begin
                sub_cnt_d = '0;
                if (cm_acc_q != CM_MAX) begin
                    cm_acc_d = cm_acc_q + CM_W'(1);
                end
            end else begin
                sub_cnt_d = sub_cnt_q + SUB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q    <= IDLE;
            us_cnt_q   <= '0;
            rise_us_q  <= '0;
            sub_cnt_q  <= '0;
            cm_acc_q   <= '0;
            distance_q <= '0;
            trig_q     <= 1'b0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            if (state_q != IDLE) begin
                us_cnt_q <= us_cnt_d;
            end
            case (state_q)
                IDLE: begin
                    if (start || auto_en) begin
                        state_q  <= TRIG;
                        trig_q   <= 1'b1;
                        us_cnt_q <= '0;
                    end
                end
                TRIG: begin
                    // The tick that completes TRIG_US ticks ends the pulse.
                    if (clk_usec && (us_cnt_q == TRIG_LAST)) begin
                        trig_q  <= 1'b0;
                        state_q <= WAIT_H;
                    end
                end
                WAIT_H: begin
                    // Only a real 0->1 edge starts a measurement; a level
                    // already high on entry produced its pulse earlier.
                    if (echo_rise) begin
                        sub_cnt_q <= '0;
                        cm_acc_q  <= '0;
                        rise_us_q <= us_cnt_d;
                        state_q   <= MEAS;
                    end else if (us_cnt_q >= TIMEOUT_LIM) begin
                        timeout_q <= 1'b1;
                        state_q   <= HOLD;
                    end
                end
                MEAS: begin
                    sub_cnt_q <= sub_cnt_d;
                    cm_acc_q  <= cm_acc_d;
                    if (echo_fall) begin
                        // Include any cm step from a tick in this same cycle.
                        distance_q <= cm_acc_d;
                        valid_q    <= 1'b1;
                        state_q    <= HOLD;
                    end else if (echo_us >= TIMEOUT_LIM) begin
                        timeout_q <= 1'b1;
                        state_q   <= HOLD;
                    end
                end
                HOLD: begin
                    if (us_cnt_q >= PERIOD_LIM) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    trig_q  <= 1'b0;
                end
            endcase
        end
    end

    assign trig        = trig_q;
    assign distance_cm = distance_q;
    assign valid       = valid_q;
    assign timeout_err = timeout_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_sr04_ranger.sv
`timescale 1ns/1ps
module tb_sr04_ranger;
    localparam int TICK    = 3;     // clk cycles per usec tick, keeps the run short
    localparam int TIMEOUT = 1250;
    localparam int PERIOD  = 1300;
    localparam int CM_W    = 12;
    localparam int WAIT_LIM = (PERIOD + 200) * TICK;

    logic            clk = 1'b0;
    logic            reset_p = 1'b1;
    logic            clk_usec = 1'b0;
    logic            start = 1'b0;
    logic            auto_en = 1'b0;
    logic            echo = 1'b0;
    logic            trig, valid, timeout_err, busy;
    logic [CM_W-1:0] distance_cm;
    logic            trig_s, valid_s, to_s, busy_s;
    logic [3:0]      dist_s;

    int n_checks = 0;
    int n_fail   = 0;

    sr04_ranger #(
        .TRIG_US(11), .US_PER_CM(58), .TIMEOUT_US(TIMEOUT), .PERIOD_US(PERIOD), .CM_W(CM_W)
    ) dut (
        .clk(clk), .reset_p(reset_p), .clk_usec(clk_usec), .start(start),
        .auto_en(auto_en), .echo(echo), .trig(trig), .distance_cm(distance_cm),
        .valid(valid), .timeout_err(timeout_err), .busy(busy)
    );

    // Narrow-distance instance sharing all stimulus, used for saturation.
    sr04_ranger #(
        .TRIG_US(11), .US_PER_CM(58), .TIMEOUT_US(TIMEOUT), .PERIOD_US(PERIOD), .CM_W(4)
    ) dut_sat (
        .clk(clk), .reset_p(reset_p), .clk_usec(clk_usec), .start(start),
        .auto_en(auto_en), .echo(echo), .trig(trig_s), .distance_cm(dist_s),
        .valid(valid_s), .timeout_err(to_s), .busy(busy_s)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (TICK - 1) @(negedge clk);
            clk_usec = 1'b1;
            @(negedge clk);
            clk_usec = 1'b0;
        end
    end

    // Monitor: event counters sampled on the falling edge.
    longint cyc = 0;
    int     valid_cnt = 0, to_cnt = 0, both_cnt = 0, sat_valid_cnt = 0;
    int     trig_hi = 0, last_trig_hi = 0;
    logic   trig_prev = 1'b0;
    longint to_cyc = 0;
    longint rise_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) valid_cnt <= valid_cnt + 1;
        if (timeout_err) begin
            to_cnt <= to_cnt + 1;
            to_cyc <= cyc;
        end
        if (valid && timeout_err) both_cnt <= both_cnt + 1;
        if (valid_s) sat_valid_cnt <= sat_valid_cnt + 1;
        if (trig) trig_hi <= trig_hi + 1;
        if (trig && !trig_prev) rise_cyc.push_back(cyc);
        if (!trig && trig_prev) begin
            last_trig_hi <= trig_hi;
            trig_hi      <= 0;
        end
        trig_prev <= trig;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_us(input int n);
        repeat (n * TICK) @(negedge clk);
    endtask

    task automatic wait_trig(input logic lvl, input string name);
        int k = 0;
        while (trig !== lvl && k < WAIT_LIM) begin
            @(negedge clk);
            k++;
        end
        check({name, " trig level"}, longint'(trig), longint'(lvl));
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy !== 1'b0 && k < WAIT_LIM) begin
            @(negedge clk);
            k++;
        end
        check({name, " busy drops"}, longint'(busy), 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    typedef struct {
        int width_us;   // 0 means no echo at all
        int exp_cm;
        int exp_valid;
        int exp_to;
        int exp_sat_cm; // -1: narrow instance not checked
    } vec_t;

    vec_t   vecs[5];
    int     v0, t0, sv0, r0, k;
    longint e_cyc;
    string  nm;

    initial begin
        vecs[0] = '{57,   0,  1, 0, -1};
        vecs[1] = '{58,   1,  1, 0, -1};
        vecs[2] = '{1159, 19, 1, 0, -1};
        vecs[3] = '{1000, 17, 1, 0, 15};
        vecs[4] = '{0,    17, 0, 1, -1};

        // Reset state
        repeat (5) @(negedge clk);
        check("reset trig", longint'(trig), 0);
        check("reset distance", longint'(distance_cm), 0);
        check("reset valid", longint'(valid), 0);
        check("reset timeout", longint'(timeout_err), 0);
        check("reset busy", longint'(busy), 0);
        reset_p = 1'b0;
        wait_us(5);
        check("idle without start", longint'(busy), 0);

        // Single shot: 200 us gap, 580 us echo, start held during MEAS,
        // short echo glitch during HOLD.
        v0 = valid_cnt; t0 = to_cnt;
        pulse_start();
        wait_trig(1'b1, "ss");
        wait_trig(1'b0, "ss");
        @(negedge clk);
        check_range("ss trig high clks", last_trig_hi, 10 * TICK, 11 * TICK);
        wait_us(200);
        echo = 1'b1;
        wait_us(300);
        start = 1'b1;
        wait_us(50);
        start = 1'b0;
        wait_us(230);
        echo = 1'b0;
        wait_us(2);
        check("ss distance", longint'(distance_cm), 10);
        check("ss valid count", valid_cnt - v0, 1);
        wait_us(100);
        echo = 1'b1;
        wait_us(5);
        echo = 1'b0;
        wait_idle("ss");
        check_range("ss busy time clks", cyc - rise_cyc[rise_cyc.size() - 1],
                    (PERIOD - 1) * TICK, (PERIOD + 1) * TICK + 3);
        wait_us(20);
        check("ss start not queued", longint'(busy), 0);
        check("ss glitch no valid", valid_cnt - v0, 1);
        check("ss no timeout", to_cnt - t0, 0);
        $display("single shot: 580 us -> %0d cm", distance_cm);

        // Table-driven widths and the no-echo timeout
        for (int i = 0; i < 5; i++) begin
            nm = $sformatf("vec%0d", i);
            v0 = valid_cnt; t0 = to_cnt; sv0 = sat_valid_cnt;
            pulse_start();
            wait_trig(1'b1, nm);
            wait_trig(1'b0, nm);
            if (vecs[i].width_us > 0) begin
                wait_us(20);
                echo = 1'b1;
                wait_us(vecs[i].width_us);
                echo = 1'b0;
            end
            wait_idle(nm);
            @(negedge clk);
            check({nm, " distance"}, longint'(distance_cm), vecs[i].exp_cm);
            check({nm, " valid count"}, valid_cnt - v0, vecs[i].exp_valid);
            check({nm, " timeout count"}, to_cnt - t0, vecs[i].exp_to);
            if (vecs[i].exp_to != 0) begin
                check_range({nm, " timeout clks"}, to_cyc - rise_cyc[rise_cyc.size() - 1],
                            (TIMEOUT - 1) * TICK, (TIMEOUT + 1) * TICK);
            end
            if (vecs[i].exp_sat_cm >= 0) begin
                check({nm, " sat distance"}, longint'(dist_s), vecs[i].exp_sat_cm);
                check({nm, " sat valid count"}, sat_valid_cnt - sv0, 1);
            end
            $display("vec %0d: width %0d us -> %0d cm, valid %0d, timeout %0d", i,
                     vecs[i].width_us, distance_cm, valid_cnt - v0, to_cnt - t0);
        end

        // Echo stuck high: timeout measured from the rise
        v0 = valid_cnt; t0 = to_cnt;
        pulse_start();
        wait_trig(1'b1, "stuck");
        wait_trig(1'b0, "stuck");
        wait_us(20);
        echo = 1'b1;
        e_cyc = cyc;
        k = 0;
        while (to_cnt == t0 && k < WAIT_LIM) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check_range("stuck timeout clks", to_cyc - e_cyc, (TIMEOUT - 1) * TICK, (TIMEOUT + 1) * TICK + 6);
        echo = 1'b0;
        wait_idle("stuck");
        check("stuck timeout count", to_cnt - t0, 1);
        check("stuck no valid", valid_cnt - v0, 0);
        check("stuck distance held", longint'(distance_cm), 17);
        $display("stuck echo: timeout after %0d clk, distance %0d cm", to_cyc - e_cyc, distance_cm);

        // Echo already high before WAIT_H: only the fresh rise counts
        v0 = valid_cnt; t0 = to_cnt;
        echo = 1'b1;
        pulse_start();
        wait_trig(1'b1, "prehigh");
        wait_trig(1'b0, "prehigh");
        wait_us(100);
        echo = 1'b0;
        wait_us(20);
        echo = 1'b1;
        wait_us(580);
        echo = 1'b0;
        wait_idle("prehigh");
        check("prehigh distance", longint'(distance_cm), 10);
        check("prehigh valid count", valid_cnt - v0, 1);
        check("prehigh timeout count", to_cnt - t0, 0);
        $display("pre-high echo: fresh 580 us -> %0d cm", distance_cm);

        // Auto mode: three cycles, auto_en dropped during the third
        v0 = valid_cnt;
        r0 = rise_cyc.size();
        auto_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nm = $sformatf("auto%0d", i);
            wait_trig(1'b1, nm);
            wait_trig(1'b0, nm);
            wait_us(20);
            echo = 1'b1;
            if (i == 2) begin
                wait_us(100);
                auto_en = 1'b0;
                wait_us(1060);
            end else begin
                wait_us(1160);
            end
            echo = 1'b0;
            wait_us(2);
            check({nm, " distance"}, longint'(distance_cm), 20);
            check({nm, " valid count"}, valid_cnt - v0, i + 1);
            $display("auto %0d: 1160 us -> %0d cm", i, distance_cm);
        end
        wait_idle("auto");
        wait_us(100);
        check("auto stays idle", longint'(busy), 0);
        check("auto trigger count", rise_cyc.size() - r0, 3);
        check_range("auto period 1", rise_cyc[r0 + 1] - rise_cyc[r0], (PERIOD - 1) * TICK, (PERIOD + 1) * TICK + 3);
        check_range("auto period 2", rise_cyc[r0 + 2] - rise_cyc[r0 + 1], (PERIOD - 1) * TICK, (PERIOD + 1) * TICK + 3);

        // Reset 300 us into an echo
        pulse_start();
        wait_trig(1'b1, "rst");
        wait_trig(1'b0, "rst");
        wait_us(20);
        echo = 1'b1;
        wait_us(300);
        v0 = valid_cnt; t0 = to_cnt;
        reset_p = 1'b1;
        #1;
        check("rst trig", longint'(trig), 0);
        check("rst busy", longint'(busy), 0);
        check("rst distance", longint'(distance_cm), 0);
        check("rst valid", longint'(valid), 0);
        check("rst timeout", longint'(timeout_err), 0);
        echo = 1'b0;
        repeat (20) @(negedge clk);
        reset_p = 1'b0;
        wait_us(5);
        check("rst no valid strobe", valid_cnt - v0, 0);
        check("rst no timeout strobe", to_cnt - t0, 0);
        check("rst idle after release", longint'(busy), 0);
        $display("reset mid-measurement: distance %0d cm, busy %0d", distance_cm, busy);

        pulse_start();
        wait_trig(1'b1, "post");
        wait_trig(1'b0, "post");
        wait_us(20);
        echo = 1'b1;
        wait_us(580);
        echo = 1'b0;
        wait_idle("post");
        check("post distance", longint'(distance_cm), 10);
        check("post valid count", valid_cnt - v0, 1);
        $display("after reset: 580 us -> %0d cm", distance_cm);

        check("valid and timeout together", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
